// File: rtl/sequence_reader.sv
// Streams elementSeq then nodeSeq entries, each tagged with slot index and x offset.
// Read-only consumer of the sort stage's sequence RAMs, one word per 3 cycles.
module sequence_reader #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned WIDTH_W = 10
) (
  input  logic                        clk,
  input  logic                        program_reset_n,
  input  logic                        start_process,
  output logic                        end_process,
  input  logic [ADDR_W-1:0]           numElements,
  input  logic [ADDR_W-1:0]           numNodes,
  input  logic [WIDTH_W-1:0]          block_width,
  output logic [ADDR_W-1:0]           elementSeq_addr,
  output logic                        elementSeq_wren,
  input  logic [ADDR_W-1:0]           elementSeq_out,
  output logic [ADDR_W-1:0]           nodeSeq_addr,
  output logic                        nodeSeq_wren,
  input  logic [ADDR_W-1:0]           nodeSeq_out,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_kind,
  output logic [ADDR_W-1:0]           out_index,
  output logic [ADDR_W-1:0]           out_value,
  output logic [ADDR_W+WIDTH_W-1:0]   out_x
);

  localparam int unsigned XW = ADDR_W + WIDTH_W;

  typedef enum logic [2:0] {IDLE, E_RD, E_WT, E_OUT, N_RD, N_WT, N_OUT, DONE} state_t;

  state_t              state, stateNxt;
  logic [ADDR_W-1:0]   numElemL, numElemLNxt, numNodeL, numNodeLNxt;
  logic [WIDTH_W-1:0]  bwL, bwLNxt;
  logic [ADDR_W-1:0]   i, iNxt, iInc;
  logic [XW-1:0]       x, xNxt, xInc;
  logic [ADDR_W-1:0]   eAddr, eAddrNxt, nAddr, nAddrNxt;
  logic                outValid, outValidNxt, outKind, outKindNxt, endProc, endProcNxt;
  logic [ADDR_W-1:0]   outIndex, outIndexNxt, outValue, outValueNxt;
  logic [XW-1:0]       outX, outXNxt;

  assign iInc = i + ADDR_W'(1);
  assign xInc = x + XW'(bwL);

  // The next address is loaded on the edge that enters a *_RD state, so the
  // RAM samples it one edge later and data is captured at the end of *_WT.
  always_comb begin
    stateNxt    = state;
    numElemLNxt = numElemL;
    numNodeLNxt = numNodeL;
    bwLNxt      = bwL;
    iNxt        = i;
    xNxt        = x;
    eAddrNxt    = eAddr;
    nAddrNxt    = nAddr;
    outValidNxt = outValid;
    outKindNxt  = outKind;
    outIndexNxt = outIndex;
    outValueNxt = outValue;
    outXNxt     = outX;
    endProcNxt  = endProc;
    case (state)
      IDLE: begin
        if (start_process) begin
          numElemLNxt = numElements;
          numNodeLNxt = numNodes;
          bwLNxt      = block_width;
          iNxt        = '0;
          xNxt        = '0;
          if (numElements != '0) begin
            stateNxt = E_RD;
            eAddrNxt = '0;
          end else if (numNodes != '0) begin
            stateNxt = N_RD;
            nAddrNxt = '0;
          end else begin
            stateNxt   = DONE;
            endProcNxt = 1'b1;
          end
        end
      end
      E_RD: stateNxt = E_WT;
      E_WT: begin
        stateNxt    = E_OUT;
        outValueNxt = elementSeq_out;
        outIndexNxt = i;
        outXNxt     = x;
        outKindNxt  = 1'b0;
        outValidNxt = 1'b1;
      end
      E_OUT: begin
        if (outValid && out_ready) begin
          outValidNxt = 1'b0;
          if (iInc == numElemL) begin
            iNxt = '0;
            xNxt = '0;
            if (numNodeL != '0) begin
              stateNxt = N_RD;
              nAddrNxt = '0;
            end else begin
              stateNxt   = DONE;
              endProcNxt = 1'b1;
            end
          end else begin
            iNxt     = iInc;
            xNxt     = xInc;
            eAddrNxt = iInc;
            stateNxt = E_RD;
          end
        end
      end
      N_RD: stateNxt = N_WT;
      N_WT: begin
        stateNxt    = N_OUT;
        outValueNxt = nodeSeq_out;
        outIndexNxt = i;
        outXNxt     = x;
        outKindNxt  = 1'b1;
        outValidNxt = 1'b1;
      end
      N_OUT: begin
        if (outValid && out_ready) begin
          outValidNxt = 1'b0;
          if (iInc == numNodeL) begin
            iNxt       = '0;
            xNxt       = '0;
            stateNxt   = DONE;
            endProcNxt = 1'b1;
          end else begin
            iNxt     = iInc;
            xNxt     = xInc;
            nAddrNxt = iInc;
            stateNxt = N_RD;
          end
        end
      end
      DONE: begin
        if (!start_process) begin
          stateNxt   = IDLE;
          endProcNxt = 1'b0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge program_reset_n) begin
    if (!program_reset_n) begin
      state    <= IDLE;
      numElemL <= '0;
      numNodeL <= '0;
      bwL      <= '0;
      i        <= '0;
      x        <= '0;
      eAddr    <= '0;
      nAddr    <= '0;
      outValid <= 1'b0;
      outKind  <= 1'b0;
      outIndex <= '0;
      outValue <= '0;
      outX     <= '0;
      endProc  <= 1'b0;
    end else begin
      state    <= stateNxt;
      numElemL <= numElemLNxt;
      numNodeL <= numNodeLNxt;
      bwL      <= bwLNxt;
      i        <= iNxt;
      x        <= xNxt;
      eAddr    <= eAddrNxt;
      nAddr    <= nAddrNxt;
      outValid <= outValidNxt;
      outKind  <= outKindNxt;
      outIndex <= outIndexNxt;
      outValue <= outValueNxt;
      outX     <= outXNxt;
      endProc  <= endProcNxt;
    end
  end

  assign end_process     = endProc;
  assign elementSeq_addr = eAddr;
  assign nodeSeq_addr    = nAddr;
  assign elementSeq_wren = 1'b0;
  assign nodeSeq_wren    = 1'b0;
  assign out_valid       = outValid;
  assign out_kind        = outKind;
  assign out_index       = outIndex;
  assign out_value       = outValue;
  assign out_x           = outX;

endmodule

// File: tb/tb_sequence_reader.sv
// Randomized bench for sequence_reader: RAM models plus a queue-based model of the
// expected stream, cycle counts and stall/hold behaviour.
module tb_sequence_reader;

  localparam int AW = 5;
  localparam int WW = 10;
  localparam int XW = AW + WW;

  logic          clk = 1'b0;
  logic          program_reset_n;
  logic          start_process;
  logic          end_process;
  logic [AW-1:0] numElements, numNodes;
  logic [WW-1:0] block_width;
  logic [AW-1:0] elementSeq_addr, nodeSeq_addr;
  logic          elementSeq_wren, nodeSeq_wren;
  logic [AW-1:0] eQ, nQ;
  logic          out_valid, out_ready, out_kind;
  logic [AW-1:0] out_index, out_value;
  logic [XW-1:0] out_x;

  always #5 clk = ~clk;

  sequence_reader #(.ADDR_W(AW), .WIDTH_W(WW)) dut (
    .clk             (clk),
    .program_reset_n (program_reset_n),
    .start_process   (start_process),
    .end_process     (end_process),
    .numElements     (numElements),
    .numNodes        (numNodes),
    .block_width     (block_width),
    .elementSeq_addr (elementSeq_addr),
    .elementSeq_wren (elementSeq_wren),
    .elementSeq_out  (eQ),
    .nodeSeq_addr    (nodeSeq_addr),
    .nodeSeq_wren    (nodeSeq_wren),
    .nodeSeq_out     (nQ),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_kind        (out_kind),
    .out_index       (out_index),
    .out_value       (out_value),
    .out_x           (out_x)
  );

  // Synchronous-read RAMs with one cycle of latency
  logic [AW-1:0] eMem [32];
  logic [AW-1:0] nMem [32];
  always @(posedge clk) begin
    eQ <= eMem[elementSeq_addr];
    nQ <= nMem[nodeSeq_addr];
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic          kind;
    logic [AW-1:0] idx;
    logic [AW-1:0] val;
    logic [XW-1:0] x;
  } word_t;

  word_t expQ[$];
  int nChecks = 0;
  int nFails  = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] allOuts();
    return 64'({end_process, out_valid, out_kind, out_index, out_value, out_x,
                elementSeq_addr, nodeSeq_addr, elementSeq_wren, nodeSeq_wren});
  endfunction

  task automatic runTest(input int nE, input int nN, input int bw, input int readyMode,
                         input bit randFill, input bit scramble);
    int    words, stalls, kCyc;
    bit    firstSeen, holding, done;
    word_t held, w;
    logic [AW-1:0] heldEA, heldNA;
    @(negedge clk);
    if (randFill) begin
      for (int k = 0; k < 32; k++) begin
        eMem[k] = AW'($urandom);
        nMem[k] = AW'($urandom);
      end
    end
    expQ.delete();
    for (int k = 0; k < nE; k++) begin
      w.kind = 1'b0; w.idx = AW'(k); w.val = eMem[k]; w.x = XW'(k * bw);
      expQ.push_back(w);
    end
    for (int k = 0; k < nN; k++) begin
      w.kind = 1'b1; w.idx = AW'(k); w.val = nMem[k]; w.x = XW'(k * bw);
      expQ.push_back(w);
    end
    numElements   = AW'(nE);
    numNodes      = AW'(nN);
    block_width   = WW'(bw);
    start_process = 1'b1;
    out_ready     = 1'b1;
    @(posedge clk);
    #1 kCyc = int'(cyc);
    words = 0; stalls = 0; firstSeen = 0; holding = 0; done = 0;
    for (int c = 0; c < 3000 && !done; c++) begin
      @(negedge clk);
      if (end_process) begin
        checkVal("runCycles", 64'(int'(cyc) - kCyc), 64'(3 * (nE + nN) + stalls));
        checkVal("wordsLeft", 64'(expQ.size()), 64'd0);
        checkVal("wren", 64'({elementSeq_wren, nodeSeq_wren}), 64'd0);
        done = 1;
      end else if (out_valid) begin
        if (holding)
          checkVal("stallHold",
                   64'({out_kind, out_index, out_value, out_x, elementSeq_addr, nodeSeq_addr}),
                   64'({held, heldEA, heldNA}));
        if (!firstSeen) begin
          checkVal("firstValidLat", 64'(int'(cyc) - kCyc), 64'd2);
          firstSeen = 1;
        end
        case (readyMode)
          1:       out_ready = !(words == 2 && stalls < 4);
          2:       out_ready = ($urandom_range(0, 2) != 0);
          default: out_ready = 1'b1;
        endcase
        if (out_ready) begin
          holding = 0;
          if (expQ.size() == 0) begin
            checkVal("extraWord", 64'(words + 1), 64'(nE + nN));
          end else begin
            w = expQ.pop_front();
            checkVal("kind",  64'(out_kind),  64'(w.kind));
            checkVal("index", 64'(out_index), 64'(w.idx));
            checkVal("value", 64'(out_value), 64'(w.val));
            checkVal("x",     64'(out_x),     64'(w.x));
          end
          words++;
        end else begin
          stalls++;
          holding = 1;
          held    = {out_kind, out_index, out_value, out_x};
          heldEA  = elementSeq_addr;
          heldNA  = nodeSeq_addr;
        end
      end else begin
        out_ready = (readyMode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (scramble && !done) begin
        numElements   = AW'($urandom);
        numNodes      = AW'($urandom);
        block_width   = WW'($urandom);
        start_process = 1'($urandom_range(0, 1));
      end
    end
    if (!done) checkVal("endTimeout", 64'(end_process), 64'd1);
    if (nE + nN == 0 && !scramble) begin
      repeat (3) begin
        @(negedge clk);
        checkVal("endHold", 64'(end_process), 64'd1);
      end
    end
    start_process = 1'b0;
    @(negedge clk);
    checkVal("endClear", 64'(end_process), 64'd0);
  endtask

  initial begin
    program_reset_n = 1'b0;
    start_process   = 1'b0;
    numElements     = '0;
    numNodes        = '0;
    block_width     = '0;
    out_ready       = 1'b0;
    for (int k = 0; k < 32; k++) begin
      eMem[k] = '0;
      nMem[k] = '0;
    end
    repeat (3) @(negedge clk);
    checkVal("resetOuts", allOuts(), 64'd0);
    program_reset_n = 1'b1;

    eMem[0] = 5'd4; eMem[1] = 5'd1; eMem[2] = 5'd2;
    nMem[0] = 5'd7; nMem[1] = 5'd3;
    runTest(3, 2, 40, 0, 1'b0, 1'b0);
    runTest(3, 2, 40, 1, 1'b0, 1'b0);
    runTest(0, 0, 40, 0, 1'b0, 1'b0);
    runTest(0, 4, 13, 0, 1'b1, 1'b0);
    runTest(31, 2, 1023, 0, 1'b1, 1'b0);
    runTest(31, 31, 1023, 2, 1'b1, 1'b0);

    // Reset while word 1 is on the bus
    @(negedge clk);
    numElements = 5'd4; numNodes = 5'd2; block_width = 10'd55;
    start_process = 1'b1; out_ready = 1'b1;
    begin
      bit found;
      found = 0;
      for (int c = 0; c < 50 && !found; c++) begin
        @(negedge clk);
        if (out_valid && out_index == 5'd1) found = 1;
      end
      checkVal("abortReach", 64'(out_valid), 64'd1);
    end
    #2 program_reset_n = 1'b0;
    #1 checkVal("abortOuts", allOuts(), 64'd0);
    start_process = 1'b0;
    repeat (2) @(negedge clk);
    checkVal("abortHeld", allOuts(), 64'd0);
    program_reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkVal("idleQuiet", 64'(out_valid), 64'd0);
    end
    runTest(5, 4, 77, 0, 1'b1, 1'b0);

    runTest(6, 3, 300, 2, 1'b1, 1'b1);
    for (int r = 0; r < 8; r++)
      runTest(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 1023)), int'($urandom_range(0, 2)),
              1'b1, 1'($urandom_range(0, 1)));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
